sccb_init_sequencer: RTL and testbench
======================================

SCCB_INIT_SEQUENCER -- requirements
Module: sccb_init_sequencer

Interface
REQ-001 SHALL have parameter DEVICE_ID, default 8'h42, SCCB write ID placed on tx_id.
REQ-002 SHALL have parameter DELAY_CYCLES, default 50000, wait after a soft-reset write (1 ms at 50 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000000, watchdog limit (used only with the macro).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port go, input, 1, level; sampled high in IDLE or FINISH starts a sequence.
REQ-007 SHALL have port tx_busy, input, 1, downstream SCCB writer busy flag.
REQ-008 SHALL have port tx_start, output, 1, request level to the downstream writer.
REQ-009 SHALL have ports tx_id, tx_addr and tx_data, output, 8 each, payload of the current write.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE, FINISH or ERROR.
REQ-011 SHALL have port done, output, 1, high only in FINISH.
REQ-012 SHALL have port index, output, 5, current ROM entry.
REQ-013 SHALL have port error, output, 1, timeout flag.

Function
REQ-014 SHALL hold an internal 32-entry ROM of {addr, data}; entry {8'hFF, 8'hFF} terminates the list.
REQ-015 ROM entries 0..7 SHALL be 12/80, 12/04, 40/D0, 11/01, 0C/00, 3E/00, 8C/00, FF/FF (hex); entries 8..31 SHALL be FF/FF.
REQ-016 FSM states SHALL be IDLE, FETCH, REQ, WAIT_DONE, DELAY, FINISH and ERROR.
REQ-017 IDLE or FINISH with go=1 -> FETCH: index:=0.
REQ-018 FETCH, registering the entry onto tx_addr/tx_data: terminator -> FINISH; else -> REQ after 1 cycle.
REQ-019 REQ SHALL drive tx_start=1 until tx_busy=1 is sampled, then go to WAIT_DONE with tx_start=0 in the next cycle.
REQ-020 In REQ, if tx_busy is already 1 on entry, the block SHALL stay in REQ with tx_start=0 until tx_busy=0, then assert tx_start.
REQ-021 WAIT_DONE on tx_busy=0: if addr=8'h12 and data[7]=1 -> DELAY; else index+1 -> FETCH.
REQ-022 DELAY SHALL count exactly DELAY_CYCLES clk cycles, then set index+1 and go to FETCH.
REQ-023 index SHALL NOT wrap; with index=31 and no terminator -> FINISH.
REQ-024 go SHALL be ignored while busy=1.
REQ-025 tx_id SHALL equal DEVICE_ID at all times.
REQ-026 tx_addr and tx_data SHALL stay stable from FETCH exit until WAIT_DONE exit.
REQ-027 Handshake is level-based; tx_busy may lag tx_start by any number of cycles (slow SCCB clock).

Reset
REQ-028 On reset=1 at a clock edge, the FSM SHALL go to IDLE with index=0, tx_start=0, done=0, busy=0, error=0, tx_addr=0, tx_data=0 and delay/watchdog counters cleared.
REQ-029 Reset mid-sequence SHALL abort immediately; the downstream writer is not signalled further and the next go restarts from entry 0.

Configuration
REQ-030 With SCCB_INIT_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in REQ or WAIT_DONE, clearing on every transition between those states.
REQ-031 With SCCB_INIT_TIMEOUT_EN defined, the watchdog reaching TIMEOUT_CYCLES SHALL cause -> ERROR (error=1, tx_start=0).
REQ-032 ERROR SHALL be left only by reset or by go=1 (-> FETCH, index:=0, error:=0).
REQ-033 Without SCCB_INIT_TIMEOUT_EN, no watchdog logic SHALL exist, error SHALL be tied 0, and ERROR SHALL be unreachable.

Verification
REQ-034 Full run, DELAY_CYCLES=10, model acks after 3 cycles and busy for 20 -> 7 writes in ROM order, 10-cycle gap after 12/80, done=1, index=7.
REQ-035 tx_busy held 1 when REQ is entered -> tx_start stays 0 until tx_busy falls, then rises the next cycle.
REQ-036 reset pulse during WAIT_DONE of entry 3 -> the next cycle shows IDLE, tx_start=0, index=0; a new go rewrites from 12/80.
REQ-037 go pulsed during the sequence -> no restart and no index change; go in FINISH -> full sequence repeats.
REQ-038 With macro and TIMEOUT_CYCLES=100, tx_busy stuck 0 -> error=1 exactly 100 cycles after REQ entry, tx_start=0; go clears it.
REQ-039 Without macro, tx_busy stuck 0 -> remains in REQ indefinitely, error=0.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
// Walks a fixed register ROM and issues one SCCB write per entry via a level handshake.
// Define SCCB_INIT_TIMEOUT_EN to add a watchdog on the downstream handshake (ERROR state).
module sccb_init_sequencer #(
  parameter logic [7:0]  DEVICE_ID      = 8'h42,
  parameter int unsigned DELAY_CYCLES   = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_id,
  output logic [7:0] tx_addr,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [4:0] index,
  output logic       error
);

  // One counter times the post-soft-reset delay and, when enabled, the watchdog.
  localparam int unsigned CntMax =
      (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(DELAY_CYCLES - 1);
`ifdef SCCB_INIT_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StIdle, StFetch, StReq, StWaitDone, StDelay, StFinish, StError
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      index_q, index_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            tx_start_q, tx_start_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     entry;
  logic            step;
  logic            cnt_run;

  function automatic logic [15:0] rom_entry(input logic [4:0] idx);
    case (idx)
      5'd0:    rom_entry = 16'h1280;
      5'd1:    rom_entry = 16'h1204;
      5'd2:    rom_entry = 16'h40D0;
      5'd3:    rom_entry = 16'h1101;
      5'd4:    rom_entry = 16'h0C00;
      5'd5:    rom_entry = 16'h3E00;
      5'd6:    rom_entry = 16'h8C00;
      default: rom_entry = 16'hFFFF;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_start_d = 1'b0;
    step       = 1'b0;
    entry      = rom_entry(index_q);
    case (state_q)
      StIdle, StFinish, StError: begin
        if (go) begin
          state_d = StFetch;
          index_d = '0;
        end
      end
      StFetch: begin
        addr_d  = entry[15:8];
        data_d  = entry[7:0];
        state_d = (entry == 16'hFFFF) ? StFinish : StReq;
      end
      StReq: begin
        // Arm only once a previous transfer has released tx_busy; then hold until acked.
        if (tx_start_q && tx_busy) begin
          state_d = StWaitDone;
        end else begin
          tx_start_d = tx_start_q || !tx_busy;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (addr_q == 8'h12 && data_q[7]) begin
            state_d = StDelay;
          end else begin
            step = 1'b1;
          end
        end
      end
      StDelay: step = (cnt_q == DelayLast);
      default: state_d = StIdle;
    endcase
    if (step) begin
      if (index_q == 5'd31) begin
        state_d = StFinish;
      end else begin
        index_d = index_q + 5'd1;
        state_d = StFetch;
      end
    end
`ifdef SCCB_INIT_TIMEOUT_EN
    if ((state_q == StReq || state_q == StWaitDone) && cnt_q == TimeoutLast) begin
      state_d    = StError;
      tx_start_d = 1'b0;
    end
`endif
  end

  // Counter restarts from zero on every state change.
  always_comb begin
    cnt_run = (state_q == StDelay);
`ifdef SCCB_INIT_TIMEOUT_EN
    cnt_run = cnt_run || state_q == StReq || state_q == StWaitDone;
`endif
    cnt_d = (cnt_run && state_d == state_q) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      index_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tx_start_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_start_q <= tx_start_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_id    = DEVICE_ID;
  assign tx_addr  = addr_q;
  assign tx_data  = data_q;
  assign index    = index_q;
  assign done     = (state_q == StFinish);
  assign busy     = !(state_q == StIdle || state_q == StFinish || state_q == StError);
`ifdef SCCB_INIT_TIMEOUT_EN
  assign error    = (state_q == StError);
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Self-checking bench for sccb_init_sequencer: randomized SCCB writer model plus a
// ROM-walk reference list; covers the SCCB_INIT_TIMEOUT_EN build when that macro is defined.
module tb_sccb_init_sequencer;
  localparam int unsigned DelayCycles   = 10;
  localparam int unsigned TimeoutCycles = 100;
  localparam logic [7:0]  DevId         = 8'h42;
  localparam int          Budget        = 3000;
  localparam logic [15:0] RomSpec [8]   = '{16'h1280, 16'h1204, 16'h40D0, 16'h1101,
                                            16'h0C00, 16'h3E00, 16'h8C00, 16'hFFFF};

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       go        = 1'b0;
  logic       resp_busy = 1'b0;
  logic       man_busy  = 1'b0;
  logic       tx_busy;
  logic       tx_start, busy, done, error;
  logic [7:0] tx_id, tx_addr, tx_data;
  logic [4:0] index;

  assign tx_busy = resp_busy | man_busy;

  sccb_init_sequencer #(
    .DEVICE_ID      (DevId),
    .DELAY_CYCLES   (DelayCycles),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_id    (tx_id),
    .tx_addr  (tx_addr),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .index    (index),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  bit          resp_en = 1'b0;
  bit          rand_lat = 1'b0;
  int          reset_count = 0;
  int          hold_bad = 0;
  logic [15:0] got_q[$];
  int          start_cyc[$];
  int          fall_cyc[$];
  logic [15:0] exp_q[$];
  bit          exp_delay[$];

  // Writer model: acks a raised tx_start after a latency, stays busy, logs payload.
  initial begin : responder
    int          al, bl, rc;
    logic [15:0] pay;
    bit          stable;
    forever begin
      @(negedge clk);
      if (resp_en && tx_start === 1'b1) begin
        al = rand_lat ? int'($urandom_range(6, 1)) : 3;
        bl = rand_lat ? int'($urandom_range(25, 2)) : 20;
        rc = reset_count;
        start_cyc.push_back(cyc);
        repeat (al) @(negedge clk);
        pay = {tx_addr, tx_data};
        got_q.push_back(pay);
        resp_busy = 1'b1;
        stable = (tx_id === DevId);
        repeat (bl) begin
          @(negedge clk);
          if ({tx_addr, tx_data} !== pay || tx_id !== DevId) stable = 1'b0;
        end
        resp_busy = 1'b0;
        fall_cyc.push_back(cyc);
        if (!stable && rc == reset_count) hold_bad++;
      end
    end
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic build_expected();
    logic [15:0] e;
    for (int i = 0; i < 32; i++) begin
      e = (i < 8) ? RomSpec[i] : 16'hFFFF;
      if (e == 16'hFFFF) break;
      exp_q.push_back(e);
      exp_delay.push_back(e[15:8] == 8'h12 && e[7]);
    end
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < Budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_count++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, busy, done, error, index, tx_addr, tx_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: start/busy/done/err/idx/addr/data=%b%b%b%b %h %h %h, need 0",
               tx_start, busy, done, error, index, tx_addr, tx_data);
    end
    checks++;
    if (tx_id !== DevId) begin
      errors++;
      $display("FAIL reset_tx_id: got %h, need %h", tx_id, DevId);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b tx_start=%b, need 0 0 0", busy, done, tx_start);
    end
  endtask

  task automatic test_full_run();
    int base, sbase, hb, gap, gref;
    bit ok;
    rand_lat = 1'b0;
    resp_en  = 1'b1;
    base  = got_q.size();
    sbase = start_cyc.size();
    hb    = hold_bad;
    pulse_go();
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_run_done: done=%b after %0d cycles, need 1", done, Budget);
    end
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL full_run_count: %0d writes, need %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_run_write%0d: got %h, need %h", i,
                 (base + i < got_q.size()) ? got_q[base+i] : 16'hxxxx, exp_q[i]);
      end
    end
    // Gap from busy release to next request: entry-1 gap is the no-delay reference.
    if (fall_cyc.size() >= sbase + 2 && start_cyc.size() >= sbase + exp_q.size()) begin
      gref = start_cyc[sbase+2] - fall_cyc[sbase+1];
      for (int i = 0; i + 1 < exp_q.size(); i++) begin
        if (i != 1) begin
          gap = start_cyc[sbase+i+1] - fall_cyc[sbase+i];
          checks++;
          if (gap != gref + (exp_delay[i] ? int'(DelayCycles) : 0)) begin
            errors++;
            $display("FAIL gap_after_write%0d: gap %0d, need %0d", i, gap,
                     gref + (exp_delay[i] ? int'(DelayCycles) : 0));
          end
        end
      end
    end
    checks++;
    if (index !== 5'd7 || busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL full_run_end: index=%0d busy=%b tx_start=%b, need 7 0 0", index, busy,
               tx_start);
    end
    checks++;
    if (hold_bad != hb) begin
      errors++;
      $display("FAIL payload_hold: %0d unstable writes, need 0", hold_bad - hb);
    end
  endtask

  task automatic test_go_ignored();
    int  base;
    bit  ok;
    base = got_q.size();
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < Budget; i++) begin
      @(negedge clk);
      if (got_q.size() >= base + 2) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    pulse_go();
    @(negedge clk);
    checks++;
    if (!ok || index !== 5'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL go_ignored_idx: index=%0d busy=%b, need 1 1", index, busy);
    end
    wait_done(ok);
    checks++;
    if (!ok || got_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL go_ignored_count: %0d writes done=%b, need %0d 1", got_q.size() - base,
               done, exp_q.size());
    end
  endtask

  task automatic test_restart_from_finish();
    int base;
    bit ok;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL finish_state: done=%b, need 1", done);
    end
    base = got_q.size();
    pulse_go();
    wait_done(ok);
    checks++;
    if (!ok || got_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL restart_count: %0d writes, need %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL restart_write%0d: got %h, need %h", i,
                 (base + i < got_q.size()) ? got_q[base+i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_random_latency();
    int base, hb;
    bit ok;
    rand_lat = 1'b1;
    for (int r = 0; r < 3; r++) begin
      base = got_q.size();
      hb   = hold_bad;
      pulse_go();
      wait_done(ok);
      checks++;
      if (!ok || got_q.size() - base != exp_q.size()) begin
        errors++;
        $display("FAIL rand_run%0d_count: %0d writes, need %0d", r, got_q.size() - base,
                 exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_run%0d_write%0d: got %h, need %h", r, i,
                   (base + i < got_q.size()) ? got_q[base+i] : 16'hxxxx, exp_q[i]);
        end
      end
      checks++;
      if (hold_bad != hb || index !== 5'd7) begin
        errors++;
        $display("FAIL rand_run%0d_end: unstable=%0d index=%0d, need 0 7", r, hold_bad - hb,
                 index);
      end
    end
    rand_lat = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    base = got_q.size();
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < Budget; i++) begin
      @(negedge clk);
      if (got_q.size() >= base + 4) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || index !== 5'd3 || resp_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: index=%0d writer_busy=%b, need 3 1", index, resp_busy);
    end
    reset_count++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || index !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: tx_start=%b index=%0d busy=%b done=%b, need 0 0 0 0",
               tx_start, index, busy, done);
    end
    reset = 1'b0;
    base = got_q.size();
    pulse_go();
    wait_done(ok);
    checks++;
    if (!ok || got_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid_rerun: %0d writes, need %0d", got_q.size() - base, exp_q.size());
    end
    checks++;
    if (base >= got_q.size() || got_q[base] !== 16'h1280) begin
      errors++;
      $display("FAIL reset_mid_first: got %h, need 1280",
               (base < got_q.size()) ? got_q[base] : 16'hxxxx);
    end
  endtask

  task automatic test_busy_on_entry();
    bit stayed_low;
    resp_en  = 1'b0;
    man_busy = 1'b1;
    pulse_go();
    stayed_low = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (tx_start !== 1'b0) stayed_low = 1'b0;
    end
    checks++;
    if (!stayed_low || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_entry_hold: tx_start rose=%b busy=%b, need 0 1", !stayed_low, busy);
    end
    man_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL busy_entry_rise: tx_start=%b, need 1", tx_start);
    end
    do_reset();
  endtask

  task automatic test_stuck_busy_low();
    resp_en  = 1'b0;
    man_busy = 1'b0;
    pulse_go();
`ifdef SCCB_INIT_TIMEOUT_EN
    // REQ is entered one edge after go is taken; the error follows TimeoutCycles later.
    repeat (TimeoutCycles) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: error=%b one cycle before limit, need 0", error);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || tx_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit: error=%b tx_start=%b busy=%b, need 1 0 0", error, tx_start,
               busy);
    end
    pulse_go();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || index !== 5'd0) begin
      errors++;
      $display("FAIL timeout_clear: error=%b busy=%b index=%0d, need 0 1 0", error, busy, index);
    end
`else
    repeat (3 * TimeoutCycles) @(negedge clk);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || tx_start !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL stuck_req: error=%b busy=%b tx_start=%b done=%b, need 0 1 1 0", error, busy,
               tx_start, done);
    end
`endif
    do_reset();
  endtask

  initial begin : main
    build_expected();
    test_reset();
    test_full_run();
    test_go_ignored();
    test_restart_from_finish();
    test_random_latency();
    test_reset_mid();
    test_busy_on_entry();
    test_stuck_busy_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
